axil_req_arbiter: RTL and testbench

Round-robin scheduler that shares one AXI-Lite master port among `NUM_REQ` simple register-access requesters, such as a config sequencer, debug bridge or DMA descriptor fetch. It accepts one request at a time, runs the full AXI-Lite read or write handshake toward the slave, and returns a one-cycle response pulse to the winning requester. It sits between internal clients and an AXI-Lite slave. Its master-side port names match the protocol checker interface, so the checker binds directly to it.

---
 rtl/axil_req_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_axil_req_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite master port among NUM_REQ simple requesters.
// Optional watchdog abort is built when AXIL_ARB_TIMEOUT_EN is defined.
module axil_req_arbiter #(
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_AXI_ADDR_WIDTH = 8,
    parameter int unsigned NUM_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 16
) (
    input  logic                                  AXI_ACLK,
    input  logic                                  AXI_ARESETN,
    input  logic [NUM_REQ-1:0]                    REQ_VALID,
    input  logic [NUM_REQ-1:0]                    REQ_WRITE,
    input  logic [NUM_REQ*C_AXI_ADDR_WIDTH-1:0]   REQ_ADDR,
    input  logic [NUM_REQ*C_AXI_DATA_WIDTH-1:0]   REQ_WDATA,
    output logic [NUM_REQ-1:0]                    REQ_READY,
    output logic [NUM_REQ-1:0]                    RSP_VALID,
    output logic [C_AXI_DATA_WIDTH-1:0]           RSP_RDATA,
    output logic                                  RSP_ERR,
    output logic [C_AXI_ADDR_WIDTH-1:0]           AXI_ARADDR,
    output logic                                  AXI_ARVALID,
    input  logic                                  AXI_ARREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]           AXI_RDATA,
    input  logic [1:0]                            AXI_RRESP,
    input  logic                                  AXI_RVALID,
    output logic                                  AXI_RREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]           AXI_AWADDR,
    output logic                                  AXI_AWVALID,
    input  logic                                  AXI_AWREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]           AXI_WDATA,
    output logic                                  AXI_WVALID,
    input  logic                                  AXI_WREADY,
    input  logic [1:0]                            AXI_BRESP,
    input  logic                                  AXI_BVALID,
    output logic                                  AXI_BREADY
);

    localparam int unsigned DW   = C_AXI_DATA_WIDTH;
    localparam int unsigned AW   = C_AXI_ADDR_WIDTH;
    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWaddr, StWresp} state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     rr_ptr_q, gnt_q, gnt_idx, cand_idx, ptr_next;
    logic [NUM_REQ-1:0]  gnt_onehot, rsp_onehot;
    logic                gnt_found, gnt_fire, sel_write;
    logic [AW-1:0]       sel_addr;
    logic [DW-1:0]       sel_wdata;

    logic                arvalid_q, awvalid_q, wvalid_q;
    logic [AW-1:0]       araddr_q, awaddr_q;
    logic [DW-1:0]       wdata_q, rsp_rdata_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic                rsp_err_q;

    logic                complete, timeout_hit, rsp_fire, take_rdata, rsp_err_d;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        gnt_found  = 1'b0;
        gnt_idx    = '0;
        cand_idx   = '0;
        gnt_onehot = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand_idx = PtrW'((int'(rr_ptr_q) + i) % int'(NUM_REQ));
            if (!gnt_found && REQ_VALID[cand_idx]) begin
                gnt_found            = 1'b1;
                gnt_idx              = cand_idx;
                gnt_onehot           = '0;
                gnt_onehot[cand_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_write  = 1'b0;
        rsp_onehot = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_idx == PtrW'(i)) begin
                sel_addr  = REQ_ADDR[i*AW +: AW];
                sel_wdata = REQ_WDATA[i*DW +: DW];
                sel_write = REQ_WRITE[i];
            end
            rsp_onehot[i] = (gnt_q == PtrW'(i));
        end
    end

    assign gnt_fire  = (state_q == StIdle) && gnt_found;
    assign REQ_READY = (gnt_fire && AXI_ARESETN) ? gnt_onehot : '0;
    assign ptr_next  = (gnt_q == PtrW'(NUM_REQ - 1)) ? '0 : gnt_q + PtrW'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (gnt_found) state_d = sel_write ? StWaddr : StRaddr;
            StRaddr: if (AXI_ARREADY) state_d = StRdata;
            StRdata: if (AXI_RVALID) state_d = StIdle;
            // AW and W may complete in either order; leave once neither is pending.
            StWaddr: if ((!awvalid_q || AXI_AWREADY) && (!wvalid_q || AXI_WREADY))
                         state_d = StWresp;
            StWresp: if (AXI_BVALID) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign complete = ((state_q == StRdata) && AXI_RVALID) ||
                      ((state_q == StWresp) && AXI_BVALID);

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] to_cnt_q;
    logic            aborted_q;

    // A timed-out transaction still drains on AXI, but its real completion is dropped.
    assign timeout_hit = (state_q != StIdle) && !aborted_q && !complete &&
                         (to_cnt_q == CntW'(TIMEOUT_CYCLES));
    assign rsp_fire    = (complete && !aborted_q) || timeout_hit;
    assign take_rdata  = complete && !aborted_q && (state_q == StRdata);

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            to_cnt_q  <= '0;
            aborted_q <= 1'b0;
        end else begin
            if (gnt_fire) begin
                to_cnt_q <= CntW'(1);
            end else if ((state_q != StIdle) && !aborted_q && !timeout_hit) begin
                to_cnt_q <= to_cnt_q + CntW'(1);
            end
            if (state_q == StIdle) begin
                aborted_q <= 1'b0;
            end else if (timeout_hit) begin
                aborted_q <= 1'b1;
            end
        end
    end

    logic unused_resp;
    assign unused_resp = ^{AXI_RRESP[0], AXI_BRESP[0]};
`else
    assign timeout_hit = 1'b0;
    assign rsp_fire    = complete;
    assign take_rdata  = complete && (state_q == StRdata);

    logic unused_cfg;
    assign unused_cfg = ^{AXI_RRESP[0], AXI_BRESP[0], (TIMEOUT_CYCLES != 0)};
`endif

    assign rsp_err_d = timeout_hit | ((state_q == StRdata) ? AXI_RRESP[1] : AXI_BRESP[1]);

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            araddr_q    <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            if (gnt_fire) begin
                gnt_q <= gnt_idx;
                if (sel_write) begin
                    awaddr_q  <= sel_addr;
                    wdata_q   <= sel_wdata;
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                end else begin
                    araddr_q  <= sel_addr;
                    arvalid_q <= 1'b1;
                end
            end
            if (arvalid_q && AXI_ARREADY) arvalid_q <= 1'b0;
            if (awvalid_q && AXI_AWREADY) awvalid_q <= 1'b0;
            if (wvalid_q && AXI_WREADY)   wvalid_q  <= 1'b0;
            if (rsp_fire) begin
                rsp_valid_q <= rsp_onehot;
                rsp_err_q   <= rsp_err_d;
                rr_ptr_q    <= ptr_next;
            end
            if (take_rdata) rsp_rdata_q <= AXI_RDATA;
        end
    end

    assign RSP_VALID   = rsp_valid_q;
    assign RSP_RDATA   = rsp_rdata_q;
    assign RSP_ERR     = rsp_err_q;
    assign AXI_ARADDR  = araddr_q;
    assign AXI_ARVALID = arvalid_q;
    assign AXI_RREADY  = (state_q == StRdata);
    assign AXI_AWADDR  = awaddr_q;
    assign AXI_AWVALID = awvalid_q;
    assign AXI_WDATA   = wdata_q;
    assign AXI_WVALID  = wvalid_q;
    assign AXI_BREADY  = (state_q == StWresp);

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Bench for axil_req_arbiter: directed scenarios plus randomized transactions
// checked against a round-robin reference model.
module tb_axil_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0, req_write = '0, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [DW-1:0]   rsp_rdata, rdata_in = '0, wdata_out;
    logic            rsp_err;
    logic [AW-1:0]   araddr, awaddr;
    logic            arvalid, arready = 1'b0, rvalid = 1'b0, rready;
    logic            awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic            bvalid = 1'b0, bready;
    logic [1:0]      rresp = '0, bresp = '0;

    int              n_cmp = 0;
    int              n_fail = 0;
    int              model_ptr = 0;
    logic [DW-1:0]   exp_rdata = '0;
    int              w;

    always #5 clk = ~clk;

    axil_req_arbiter dut (
        .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
        .REQ_VALID(req_valid), .REQ_WRITE(req_write), .REQ_ADDR(req_addr),
        .REQ_WDATA(req_wdata), .REQ_READY(req_ready), .RSP_VALID(rsp_valid),
        .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
        .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
        .AXI_RDATA(rdata_in), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready),
        .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
        .AXI_WDATA(wdata_out), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
        .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First requesting index at or after the model pointer, wrapping around.
    function automatic int pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [63:0] onehot(input int idx);
        return (idx < 0) ? 64'd0 : (64'd1 << idx);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_ar"}, {araddr, arvalid, rready}, 0);
        chk({tag, "_aw"}, {awaddr, awvalid, wvalid, bready}, 0);
        chk({tag, "_wdata"}, wdata_out, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 4'hF;
        {arready, rvalid, awready, wready, bvalid} = '0;
        @(negedge clk);
        #1;
        chk_all_zero("reset");
        req_valid = '0;
        rst_n = 1'b1;
        model_ptr = 0;
        exp_rdata = '0;
    endtask

    // Inputs for the grant cycle are already driven; returns in the response cycle.
    // d1/d2: AR and R waits (read) or AW and W waits (write); d3: B wait.
    task automatic txn(input bit keep, input int d1, input int d2, input int d3,
                       input logic [1:0] resp, input logic [DW-1:0] rdat);
        int            g;
        bit            is_wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [N-1:0]  hold;
        #1;
        g = pick(req_valid);
        chk("grant", req_ready, onehot(g));
        if (g < 0) return;
        is_wr = req_write[g];
        a     = req_addr[g*AW +: AW];
        d     = req_wdata[g*DW +: DW];
        hold  = keep ? req_valid : '0;
        @(negedge clk);
        req_valid = hold;
        if (!is_wr) begin
            for (int c = 0; c <= d1; c++) begin
                if (c > 0) @(negedge clk);
                arready = (c == d1);
                #1;
                chk("arvalid", arvalid, 1);
                chk("araddr", araddr, a);
                chk("busy_ar", req_ready, 0);
            end
            @(negedge clk);
            arready = 1'b0;
            for (int c = 0; c <= d2; c++) begin
                if (c > 0) @(negedge clk);
                rvalid   = (c == d2);
                rdata_in = rdat;
                rresp    = resp;
                #1;
                chk("rready", rready, 1);
                chk("arvalid_off", arvalid, 0);
                chk("busy_r", req_ready, 0);
            end
            exp_rdata = rdat;
        end else begin
            for (int c = 0; c <= ((d1 > d2) ? d1 : d2); c++) begin
                if (c > 0) @(negedge clk);
                awready = (c == d1);
                wready  = (c == d2);
                #1;
                chk("awvalid", awvalid, (c <= d1));
                chk("wvalid", wvalid, (c <= d2));
                chk("awaddr", awaddr, a);
                chk("wdata", wdata_out, d);
                chk("bready_early", bready, 0);
                chk("busy_w", req_ready, 0);
            end
            @(negedge clk);
            awready = 1'b0;
            wready  = 1'b0;
            for (int c = 0; c <= d3; c++) begin
                if (c > 0) @(negedge clk);
                bvalid = (c == d3);
                bresp  = resp;
                #1;
                chk("bready", bready, 1);
                chk("aw_w_off", {awvalid, wvalid}, 0);
            end
        end
        @(negedge clk);
        rvalid = 1'b0;
        bvalid = 1'b0;
        #1;
        chk("rsp_valid", rsp_valid, onehot(g));
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", rsp_err, resp[1]);
        model_ptr = (g + 1) % N;
    endtask

    initial begin
        apply_reset();

        // Single read from requester 1, zero-wait slave.
        @(negedge clk);
        req_valid = 4'b0010;
        req_write = '0;
        req_addr[1*AW +: AW] = 8'h10;
        txn(1'b0, 0, 0, 0, 2'b00, 32'hCAFEF00D);

        // Write from requester 0 with AW accepted at 1 and W at 3, B at 5.
        @(negedge clk);
        req_valid = 4'b0001;
        req_write = 4'b0001;
        req_addr[0 +: AW]  = 8'h04;
        req_wdata[0 +: DW] = 32'h12345678;
        txn(1'b0, 0, 2, 1, 2'b00, 32'h0);

        // All four requesting continuously: grants rotate 0,1,2,3,0.
        apply_reset();
        @(negedge clk);
        req_valid = 4'hF;
        req_write = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            chk("fair_ptr", pick(4'hF), k % N);
            txn(1'b1, 0, 0, 0, 2'b00, 32'hA000_0000 + k);
        end
        req_valid = '0;

        // Slave error on a write from requester 2.
        @(negedge clk);
        req_valid = 4'b0100;
        req_write = 4'b0100;
        req_addr[2*AW +: AW]  = 8'h88;
        req_wdata[2*DW +: DW] = 32'hDEADBEEF;
        txn(1'b0, 1, 0, 2, 2'b10, 32'h0);

        // Reset while waiting in the read-data phase abandons the transaction.
        @(negedge clk);
        req_valid = 4'b1000;
        req_write = '0;
        req_addr[3*AW +: AW] = 8'h3C;
        #1;
        w = pick(req_valid);
        chk("mid_grant", req_ready, onehot(w));
        @(negedge clk);
        req_valid = '0;
        arready = 1'b1;
        #1;
        chk("mid_arvalid", arvalid, 1);
        @(negedge clk);
        arready = 1'b0;
        #1;
        chk("mid_rready", rready, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        model_ptr = 0;
        exp_rdata = '0;
        @(negedge clk);
        rvalid = 1'b1;
        rdata_in = 32'h5555AAAA;
        #1;
        chk("mid_rready_off", rready, 0);
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        chk("mid_no_rsp", rsp_valid, 0);
        chk("mid_rdata_kept", rsp_rdata, 0);

`ifdef AXIL_ARB_TIMEOUT_EN
        // Slave holds RVALID back far past the watchdog limit.
        @(negedge clk);
        req_valid = 4'b0001;
        req_write = '0;
        req_addr[0 +: AW] = 8'h20;
        #1;
        w = pick(req_valid);
        chk("to_grant", req_ready, onehot(w));
        @(negedge clk);
        req_valid = '0;
        arready = 1'b1;
        #1;
        chk("to_arvalid", arvalid, 1);
        for (int c = 2; c <= 31; c++) begin
            @(negedge clk);
            arready  = 1'b0;
            rvalid   = (c == 31);
            rdata_in = 32'h0BAD0BAD;
            #1;
            chk("to_rready", rready, 1);
            chk("to_pulse", rsp_valid, (c == 17) ? onehot(w) : 64'd0);
            if (c == 17) begin
                chk("to_err", rsp_err, 1);
                chk("to_rdata", rsp_rdata, exp_rdata);
            end
        end
        model_ptr = (w + 1) % N;
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        chk("to_late_drop", rsp_valid, 0);
        chk("to_rdata_kept", rsp_rdata, exp_rdata);
        req_valid = 4'b0010;
        req_addr[1*AW +: AW] = 8'h44;
        txn(1'b0, 0, 0, 0, 2'b00, 32'h600D600D);
        req_valid = '0;
`endif

        // Randomized traffic; each new request set is driven in the previous response cycle.
        @(negedge clk);
        for (int it = 0; it < 40; it++) begin
            req_valid = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                req_write[i]           = 1'($urandom_range(0, 1));
                req_addr[i*AW +: AW]   = AW'($urandom);
                req_wdata[i*DW +: DW]  = $urandom;
            end
            txn(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), 2'($urandom), $urandom);
        end
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("final_idle", rsp_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
